branch_history_table: RTL and testbench

Parametrised table of saturating branch-prediction counters, indexed by PC, for the fetch stage's branch predictor. It generalises the 2-bit taken/not-taken FSM to ENTRIES counters of CTR_WIDTH bits. The table has a registered lookup port, a read-modify-write update port, same-cycle update-to-lookup forwarding, and a sweeping initialise/flush state machine. Fetch issues lookups; the resolve stage of the pipeline sends updates.

---
 rtl/branch_history_table.sv | 141 ++++++++++++++
 tb/tb_branch_history_table.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_table.sv
// Table of saturating branch-prediction counters indexed by PC, with a
// registered lookup port, a read-modify-write update port and an init/flush sweep.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweeping INIT_VALUE into every entry, traffic dropped
// ST_RUN  | table valid, lookups and updates accepted
module branch_history_table #(
  parameter int ENTRIES    = 64,
  parameter int CTR_WIDTH  = 2,
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_LSB  = 2,
  parameter int INIT_VALUE = 2**(CTR_WIDTH-1)-1
) (
  input  logic                 bht_clk,
  input  logic                 bht_rst_n,
  input  logic                 bht_flush,
  output logic                 bht_ready,
  input  logic                 bht_lookup_valid,
  input  logic [PC_WIDTH-1:0]  bht_lookup_pc,
  output logic                 bht_pred_valid,
  output logic                 bht_pred_taken,
  output logic                 bht_pred_strong,
  output logic [CTR_WIDTH-1:0] bht_pred_ctr,
  input  logic                 bht_update_valid,
  input  logic [PC_WIDTH-1:0]  bht_update_pc,
  input  logic                 bht_update_taken
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(INIT_VALUE);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(ENTRIES-1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     sweep_idx_q, sweep_idx_d;
  logic [CTR_WIDTH-1:0] ctr_mem [ENTRIES];

  logic                 pred_valid_q, pred_taken_q, pred_strong_q;
  logic [CTR_WIDTH-1:0] pred_ctr_q;

  logic [IDX_W-1:0]     lk_idx, upd_idx, wr_idx;
  logic [CTR_WIDTH-1:0] upd_cur, upd_new, lk_ctr, wr_data;
  logic                 run, lk_fire, upd_fire, wr_en;
  logic                 unused_pc;

  assign lk_idx    = bht_lookup_pc[INDEX_LSB +: IDX_W];
  assign upd_idx   = bht_update_pc[INDEX_LSB +: IDX_W];
  assign unused_pc = ^{bht_lookup_pc, bht_update_pc};

  assign run      = (state_q == ST_RUN);
  assign lk_fire  = run && bht_lookup_valid && !bht_flush;
  assign upd_fire = run && bht_update_valid && !bht_flush;

  assign upd_cur = ctr_mem[upd_idx];

  always_comb begin
    upd_new = upd_cur;
    if (bht_update_taken) begin
      if (upd_cur != CTR_MAX) upd_new = upd_cur + CTR_WIDTH'(1);
    end else begin
      if (upd_cur != '0) upd_new = upd_cur - CTR_WIDTH'(1);
    end
  end

  // write-first: a same-cycle update to the looked-up entry is forwarded
  assign lk_ctr = (upd_fire && (upd_idx == lk_idx)) ? upd_new : ctr_mem[lk_idx];

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    wr_en       = 1'b0;
    wr_idx      = upd_idx;
    wr_data     = upd_new;
    case (state_q)
      ST_INIT: begin
        if (bht_flush) begin
          sweep_idx_d = '0;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = sweep_idx_q;
          wr_data = CTR_INIT;
          if (sweep_idx_q == LAST_IDX) state_d = ST_RUN;
          else                         sweep_idx_d = sweep_idx_q + IDX_W'(1);
        end
      end
      ST_RUN: begin
        if (bht_flush) begin
          state_d     = ST_INIT;
          sweep_idx_d = '0;
        end else if (upd_fire) begin
          wr_en = 1'b1;
        end
      end
      default: begin
        state_d     = ST_INIT;
        sweep_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge bht_clk or negedge bht_rst_n) begin
    if (!bht_rst_n) begin
      state_q     <= ST_INIT;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  // storage deliberately unreset so it maps onto RAM/regfile
  always_ff @(posedge bht_clk) begin
    if (wr_en) ctr_mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge bht_clk or negedge bht_rst_n) begin
    if (!bht_rst_n) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_strong_q <= 1'b0;
      pred_ctr_q    <= '0;
    end else begin
      pred_valid_q <= lk_fire;
      if (lk_fire) begin
        pred_ctr_q    <= lk_ctr;
        pred_taken_q  <= lk_ctr[CTR_WIDTH-1];
        pred_strong_q <= (lk_ctr == '0) || (lk_ctr == CTR_MAX);
      end
    end
  end

  assign bht_ready       = run;
  assign bht_pred_valid  = pred_valid_q;
  assign bht_pred_taken  = pred_taken_q;
  assign bht_pred_strong = pred_strong_q;
  assign bht_pred_ctr    = pred_ctr_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table: a 2-bit table and a 3-bit table
// driven by the same stimulus, checked against hand-computed values.
module tb_branch_history_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;

  logic       ready,  pv,  tk,  st;
  logic [1:0] ctr;
  logic       ready3, pv3, tk3, st3;
  logic [2:0] ctr3;

  int total  = 0;
  int passed = 0;

  branch_history_table #(.ENTRIES(64), .CTR_WIDTH(2)) u_dut (
    .bht_clk(clk), .bht_rst_n(rst_n), .bht_flush(flush), .bht_ready(ready),
    .bht_lookup_valid(lookup_valid), .bht_lookup_pc(lookup_pc),
    .bht_pred_valid(pv), .bht_pred_taken(tk), .bht_pred_strong(st), .bht_pred_ctr(ctr),
    .bht_update_valid(update_valid), .bht_update_pc(update_pc),
    .bht_update_taken(update_taken)
  );

  branch_history_table #(.ENTRIES(64), .CTR_WIDTH(3)) u_dut3 (
    .bht_clk(clk), .bht_rst_n(rst_n), .bht_flush(flush), .bht_ready(ready3),
    .bht_lookup_valid(lookup_valid), .bht_lookup_pc(lookup_pc),
    .bht_pred_valid(pv3), .bht_pred_taken(tk3), .bht_pred_strong(st3), .bht_pred_ctr(ctr3),
    .bht_update_valid(update_valid), .bht_update_pc(update_pc),
    .bht_update_taken(update_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken);
    update_valid = 1'b1;
    update_pc    = pc;
    update_taken = taken;
    tick();
    update_valid = 1'b0;
  endtask

  task automatic both(input logic [31:0] lpc, input logic [31:0] upc, input logic taken);
    lookup_valid = 1'b1;
    lookup_pc    = lpc;
    update_valid = 1'b1;
    update_pc    = upc;
    update_taken = taken;
    tick();
    lookup_valid = 1'b0;
    update_valid = 1'b0;
  endtask

  task automatic expect_sweep(input string tag);
    repeat (63) tick();
    chk({tag, "_ready_63"}, ready, 1'b0);
    tick();
    chk({tag, "_ready_64"}, ready, 1'b1);
    chk({tag, "_ready3_64"}, ready3, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    lookup_valid = 1'b0; lookup_pc = '0;
    update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
    #3;
    chk("rst_ready", ready, 1'b0);
    chk("rst_pv", pv, 1'b0);
    chk("rst_tk", tk, 1'b0);
    chk("rst_st", st, 1'b0);
    chk("rst_ctr", ctr, 2'd0);

    @(negedge clk); rst_n = 1'b1;
    expect_sweep("init");

    lookup(32'h100);
    chk("init_pv", pv, 1'b1);
    chk("init_ctr", ctr, 2'd1);
    chk("init_tk", tk, 1'b0);
    chk("init_st", st, 1'b0);
    tick();
    chk("idle_pv", pv, 1'b0);
    chk("idle_ctr_hold", ctr, 2'd1);

    repeat (4) update(32'h40, 1'b1);
    lookup(32'h40);
    chk("sat_hi_ctr", ctr, 2'd3);
    chk("sat_hi_tk", tk, 1'b1);
    chk("sat_hi_st", st, 1'b1);
    repeat (5) update(32'h40, 1'b0);
    lookup(32'h40);
    chk("sat_lo_ctr", ctr, 2'd0);
    chk("sat_lo_tk", tk, 1'b0);
    chk("sat_lo_st", st, 1'b1);

    both(32'h80, 32'h80, 1'b1);
    chk("fwd_ctr", ctr, 2'd2);
    chk("fwd_tk", tk, 1'b1);
    chk("fwd_st", st, 1'b0);
    both(32'h80, 32'h84, 1'b1);
    chk("nofwd_ctr", ctr, 2'd2);
    lookup(32'h84);
    chk("other_idx_ctr", ctr, 2'd2);

    update(32'h104, 1'b1);
    update(32'h104, 1'b1);
    lookup(32'h004);
    chk("alias_ctr", ctr, 2'd3);
    lookup(32'h100);
    chk("alias_isolated", ctr, 2'd1);

    update(32'h80, 1'b1);
    repeat (3) update(32'h40, 1'b1);
    lookup(32'h40);
    chk("preflush_ctr", ctr, 2'd3);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready_drop", ready, 1'b0);
    repeat (59) tick();
    lookup_valid = 1'b1; lookup_pc = 32'h004;
    update_valid = 1'b1; update_pc = 32'h104; update_taken = 1'b1;
    tick();
    lookup_valid = 1'b0; update_valid = 1'b0;
    chk("init_lookup_pv", pv, 1'b0);
    repeat (3) tick();
    chk("flush_ready_63", ready, 1'b0);
    tick();
    chk("flush_ready_64", ready, 1'b1);
    lookup(32'h40);
    chk("flushed_40", ctr, 2'd1);
    lookup(32'h80);
    chk("flushed_80", ctr, 2'd1);
    lookup(32'h004);
    chk("dropped_upd", ctr, 2'd1);

    lookup(32'h100);
    chk("pre_rst_pv", pv, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", ready, 1'b0);
    chk("async_rst_pv", pv, 1'b0);
    chk("async_rst_ctr", ctr, 2'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (30) tick();
    chk("mid_ready", ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1'b0);
    chk("mid_rst_pv", pv, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    expect_sweep("resweep");

    lookup(32'h100);
    chk("w3_init_ctr", ctr3, 3'd3);
    chk("w3_init_tk", tk3, 1'b0);
    chk("w2_init_ctr", ctr, 2'd1);
    repeat (5) update(32'h100, 1'b1);
    lookup(32'h100);
    chk("w3_sat_ctr", ctr3, 3'd7);
    chk("w3_sat_st", st3, 1'b1);
    chk("w2_sat_ctr", ctr, 2'd3);
    update(32'h100, 1'b0);
    lookup(32'h100);
    chk("w3_dec_ctr", ctr3, 3'd6);
    chk("w3_dec_st", st3, 1'b0);
    chk("w3_dec_tk", tk3, 1'b1);
    chk("w3_pv", pv3, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
